sipo_deser: RTL and testbench
=============================

Name: sipo_deser

Overview:
Serial-in, parallel-out deserializer. It is the receive-side counterpart of the team's MSB-first PISO shifter. It samples one bit per qualified clock, assembles DATA_WIDTH-bit words MSB-first, and presents each word on a one-entry valid/ready output buffer. Frame alignment comes from an explicit sync input. Overflow of the output buffer is reported by a sticky flag.

Parameters:
DATA_WIDTH, 8, word width in bits; legal range >= 2.

Ports:
clk  input  1  clock; all logic on posedge.
rstn  input  1  reset, synchronous, active-low.
shift_en  input  1  serial_in is a valid bit this cycle.
serial_in  input  1  serial data, MSB of each word first.
sync  input  1  word-alignment strobe; restarts the bit counter.
out_ready  input  1  downstream accepts parallel_out this cycle.
out_valid  output  1  parallel_out holds an unconsumed word.
parallel_out  output  DATA_WIDTH  assembled word.
overrun  output  1  sticky: a completed word was dropped.
ovr_clr  input  1  clears overrun.
bit_cnt  output  $clog2(DATA_WIDTH)  bits of the current word received so far, range 0..DATA_WIDTH-1.

Behaviour:
- Reset (rstn=0 at posedge): shift_reg=0, bit_cnt=0, out_valid=0, parallel_out=0, overrun=0. Reset mid-word discards the partial word and any buffered word.
- Shift, when shift_en=1:
  - shift_reg <= {shift_reg[DATA_WIDTH-2:0], serial_in}.
  - bit_cnt <= bit_cnt+1.
- shift_en=0: shift_reg and bit_cnt hold. Gaps of any length between bits are legal.
- Word completion: shift_en=1 and bit_cnt==DATA_WIDTH-1 and sync=0.
  - word = {shift_reg[DATA_WIDTH-2:0], serial_in}.
  - bit_cnt wraps to 0.
- Output buffer, two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- EMPTY + completion: parallel_out <= word, go to FULL. out_valid rises the cycle after the last bit is sampled, i.e. 1-cycle latency.
- FULL + out_ready=1, no completion: go to EMPTY. parallel_out holds its last value.
- FULL + out_ready=1 + completion in the same cycle: parallel_out <= new word, stay FULL. Back-to-back words therefore lose no cycle.
- FULL + out_ready=0 + completion:
  - new word dropped; parallel_out and out_valid unchanged;
  - overrun <= 1.
- out_valid and parallel_out are stable while out_valid=1 and out_ready=0.
- sync=1 and shift_en=1: serial_in is bit 0 (MSB) of a new word.
  - bit_cnt <= 1; shift_reg shifts normally.
  - No completion occurs even if bit_cnt was DATA_WIDTH-1; the partial word is discarded.
- sync=1 and shift_en=0: bit_cnt <= 0; shift_reg holds (stale bits are shifted out by the next word).
- sync has no effect on the output buffer or on overrun.
- overrun: set has priority over ovr_clr in the same cycle. Otherwise ovr_clr=1 clears it next cycle.
- All outputs are registered. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package piso_sipo_pkg:
  - DEFAULT_DATA_WIDTH=8.
  - function cnt_w(width) returning $clog2(width).
  - typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t.
- PISO and SIPO instances import the package so that loopback widths agree.
- Natural sub-module: sipo_out_buf.
  - One-entry valid/ready register.
  - Inputs: push, push_data, out_ready.
  - Outputs: out_valid, parallel_out, drop; drop feeds the overrun set.
- The top level holds the shift register, bit counter, sync logic and overrun flag.

Test Plan:
1. After reset, send 8 bits of 0xA5 MSB-first (1,0,1,0,0,1,0,1) with shift_en=1 every cycle and out_ready=1 -> parallel_out=0xA5 and out_valid=1 exactly one cycle after the 8th bit; out_valid drops the next cycle.
2. Send 0x3C then 0xC3 back-to-back with out_ready=1, then the same with 0-3 random idle cycles between bits -> both words appear in order, one valid pulse each, overrun=0.
3. out_ready=0; send 0x11 then 0x22 -> parallel_out stays 0x11, overrun=1 the cycle after the 22's last bit. Raise out_ready -> 0x11 consumed, out_valid=0. Pulse ovr_clr -> overrun=0. Repeat with ovr_clr asserted in the completion cycle -> overrun=1.
4. Send 5 bits of junk, then sync with shift_en carrying the MSB of 0x96, then 7 more bits -> exactly one word, 0x96; the junk produces no word.
5. Assert rstn=0 after 4 bits of a word while out_valid=1 -> next cycle all outputs 0, bit_cnt=0. Send 0x5A -> received correctly.
6. Loopback: PISO(load 0xF0, then shift) -> SIPO, with sync on the first shift cycle -> parallel_out=0xF0.

Source files
------------

// File: rtl/piso_sipo_pkg.sv
// Shared definitions for the PISO/SIPO pair so that loopback widths and
// buffer state encodings agree between transmitter and receiver.
package piso_sipo_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;

    typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;

    function automatic int unsigned cnt_w(input int unsigned width);
        return $clog2(width);
    endfunction

endpackage

// File: rtl/sipo_out_buf.sv
// One-entry valid/ready output register for the deserializer. A push that
// arrives while full and not being drained is dropped and flagged.
module sipo_out_buf
    import piso_sipo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  out_ready,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] parallel_out,
    output logic                  drop
);

    buf_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= BUF_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        drop    = 1'b0;
        unique case (state_q)
            BUF_EMPTY: begin
                if (push) begin
                    data_d  = push_data;
                    state_d = BUF_FULL;
                end
            end
            BUF_FULL: begin
                if (out_ready) begin
                    // Drain and refill in one cycle keeps back-to-back words gapless.
                    if (push) begin
                        data_d = push_data;
                    end else begin
                        state_d = BUF_EMPTY;
                    end
                end else if (push) begin
                    drop = 1'b1;
                end
            end
            default: state_d = BUF_EMPTY;
        endcase
    end

    assign out_valid    = (state_q == BUF_FULL);
    assign parallel_out = data_q;

endmodule

// File: rtl/sipo_deser.sv
// Serial-in, parallel-out deserializer: MSB-first word assembly with explicit
// sync alignment, a one-entry output buffer and a sticky overrun flag.
module sipo_deser
    import piso_sipo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          shift_en,
    input  logic                          serial_in,
    input  logic                          sync,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [DATA_WIDTH-1:0]         parallel_out,
    output logic                          overrun,
    input  logic                          ovr_clr,
    output logic [$clog2(DATA_WIDTH)-1:0] bit_cnt
);

    localparam int unsigned CNT_W = cnt_w(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ovr_q, ovr_d;
    logic [DATA_WIDTH-1:0] word;
    logic                  last_bit;
    logic                  complete;
    logic                  drop;

    assign word     = {shift_q[DATA_WIDTH-2:0], serial_in};
    assign last_bit = (cnt_q == CNT_W'(DATA_WIDTH - 1));
    // A sync on the last bit position starts a new word instead of completing the old one.
    assign complete = shift_en && last_bit && !sync;

    always_comb begin
        shift_d = shift_en ? word : shift_q;
        cnt_d   = cnt_q;
        if (sync) begin
            cnt_d = shift_en ? CNT_W'(1) : '0;
        end else if (shift_en) begin
            cnt_d = last_bit ? '0 : cnt_q + CNT_W'(1);
        end
        ovr_d = ovr_q;
        if (drop) begin
            ovr_d = 1'b1;
        end else if (ovr_clr) begin
            ovr_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            shift_q <= '0;
            cnt_q   <= '0;
            ovr_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ovr_q   <= ovr_d;
        end
    end

    sipo_out_buf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_buf (
        .clk          (clk),
        .rstn         (rstn),
        .push         (complete),
        .push_data    (word),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .parallel_out (parallel_out),
        .drop         (drop)
    );

    assign overrun = ovr_q;
    assign bit_cnt = cnt_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser: a vector table for single-word and sync
// alignment cases, plus hand-written sequences for multi-cycle corners.
module tb_sipo_deser;

    logic       clk = 1'b0;
    logic       rstn;
    logic       shift_en;
    logic       serial_in;
    logic       sync;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] parallel_out;
    logic       overrun;
    logic       ovr_clr;
    logic [2:0] bit_cnt;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    sipo_deser #(
        .DATA_WIDTH (8)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .shift_en     (shift_en),
        .serial_in    (serial_in),
        .sync         (sync),
        .out_ready    (out_ready),
        .out_valid    (out_valid),
        .parallel_out (parallel_out),
        .overrun      (overrun),
        .ovr_clr      (ovr_clr),
        .bit_cnt      (bit_cnt)
    );

    // Words accepted downstream (handshake seen at the edge).
    always @(posedge clk) begin
        if (rstn && out_valid && out_ready) pulses <= pulses + 1;
    end

    typedef struct {
        logic       se;
        logic       si;
        logic       sy;
        logic       rdy;
        logic       clr;
        logic       ev;
        logic [7:0] ed;
        logic       eo;
        logic [2:0] ec;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic se, logic si, logic sy, logic rdy, logic clr,
                                logic ev, logic [7:0] ed, logic eo, logic [2:0] ec);
        vec_t v;
        v.se = se; v.si = si; v.sy = sy; v.rdy = rdy; v.clr = clr;
        v.ev = ev; v.ed = ed; v.eo = eo; v.ec = ec;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        shift_en  = 1'b0;
        serial_in = 1'b0;
        sync      = 1'b0;
        ovr_clr   = 1'b0;
    endtask

    // Shift one word MSB-first with up to max_gap idle cycles before each bit,
    // optionally asserting ovr_clr with the last bit, then check the outputs.
    task automatic send_word(input string name, input logic [7:0] w, input int max_gap,
                             input logic clr_last, input logic [7:0] exp_data,
                             input logic exp_ovr);
        for (int i = 7; i >= 0; i--) begin
            int gap;
            gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            idle_inputs();
            for (int g = 0; g < gap; g++) tick();
            shift_en  = 1'b1;
            serial_in = w[i];
            ovr_clr   = (i == 0) ? clr_last : 1'b0;
            tick();
        end
        idle_inputs();
        chk({name, " valid"}, {31'd0, out_valid}, 32'd1);
        chk({name, " data"}, {24'd0, parallel_out}, {24'd0, exp_data});
        chk({name, " ovr"}, {31'd0, overrun}, {31'd0, exp_ovr});
        chk({name, " cnt"}, {29'd0, bit_cnt}, 32'd0);
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] w96;
        logic [7:0] junk;
        logic [7:0] piso;
        a5   = 8'hA5;
        w96  = 8'h96;
        junk = 8'b1101_1000;

        rstn = 1'b0;
        out_ready = 1'b1;
        idle_inputs();
        tick();
        tick();
        chk("reset valid", {31'd0, out_valid}, 32'd0);
        chk("reset data", {24'd0, parallel_out}, 32'd0);
        chk("reset ovr", {31'd0, overrun}, 32'd0);
        chk("reset cnt", {29'd0, bit_cnt}, 32'd0);
        rstn = 1'b1;

        // Single word 0xA5, valid one cycle after the 8th bit, then drop.
        for (int i = 0; i < 7; i++) vecs.push_back(mk(1, a5[7-i], 0, 1, 0, 0, 8'h00, 0, 3'(i + 1)));
        vecs.push_back(mk(1, a5[0], 0, 1, 0, 1, 8'hA5, 0, 3'd0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 8'hA5, 0, 3'd0));
        // Five junk bits, then sync realigns onto 0x96; junk yields no word.
        for (int i = 0; i < 5; i++) vecs.push_back(mk(1, junk[7-i], 0, 1, 0, 0, 8'hA5, 0, 3'(i + 1)));
        vecs.push_back(mk(1, w96[7], 1, 1, 0, 0, 8'hA5, 0, 3'd1));
        for (int i = 1; i < 7; i++) vecs.push_back(mk(1, w96[7-i], 0, 1, 0, 0, 8'hA5, 0, 3'(i + 1)));
        vecs.push_back(mk(1, w96[0], 0, 1, 0, 1, 8'h96, 0, 3'd0));
        vecs.push_back(mk(0, 0, 0, 1, 0, 0, 8'h96, 0, 3'd0));
        // Sync without shift clears the count and holds the buffer.
        vecs.push_back(mk(1, 1, 0, 1, 0, 0, 8'h96, 0, 3'd1));
        vecs.push_back(mk(1, 0, 0, 1, 0, 0, 8'h96, 0, 3'd2));
        vecs.push_back(mk(0, 0, 1, 1, 0, 0, 8'h96, 0, 3'd0));

        foreach (vecs[k]) begin
            shift_en  = vecs[k].se;
            serial_in = vecs[k].si;
            sync      = vecs[k].sy;
            out_ready = vecs[k].rdy;
            ovr_clr   = vecs[k].clr;
            tick();
            chk($sformatf("vec%0d valid", k), {31'd0, out_valid}, {31'd0, vecs[k].ev});
            chk($sformatf("vec%0d data", k), {24'd0, parallel_out}, {24'd0, vecs[k].ed});
            chk($sformatf("vec%0d ovr", k), {31'd0, overrun}, {31'd0, vecs[k].eo});
            chk($sformatf("vec%0d cnt", k), {29'd0, bit_cnt}, {29'd0, vecs[k].ec});
        end
        idle_inputs();
        tick();

        // Back-to-back words, then with random gaps between bits.
        pulses = 0;
        out_ready = 1'b1;
        send_word("b2b 3c", 8'h3C, 0, 1'b0, 8'h3C, 1'b0);
        send_word("b2b c3", 8'hC3, 0, 1'b0, 8'hC3, 1'b0);
        send_word("gap 3c", 8'h3C, 3, 1'b0, 8'h3C, 1'b0);
        send_word("gap c3", 8'hC3, 3, 1'b0, 8'hC3, 1'b0);
        tick();
        chk("b2b pulses", pulses, 32'd4);
        chk("b2b drained", {31'd0, out_valid}, 32'd0);

        // Overrun: second word dropped while the first is held.
        out_ready = 1'b0;
        send_word("hold 11", 8'h11, 0, 1'b0, 8'h11, 1'b0);
        send_word("drop 22", 8'h22, 0, 1'b0, 8'h11, 1'b1);
        tick();
        chk("stall data", {24'd0, parallel_out}, 32'h11);
        out_ready = 1'b1;
        tick();
        chk("drain valid", {31'd0, out_valid}, 32'd0);
        chk("drain data", {24'd0, parallel_out}, 32'h11);
        chk("drain ovr sticky", {31'd0, overrun}, 32'd1);
        out_ready = 1'b0;
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("ovr clr", {31'd0, overrun}, 32'd0);
        send_word("hold2 11", 8'h11, 0, 1'b0, 8'h11, 1'b0);
        send_word("set beats clr", 8'h22, 0, 1'b1, 8'h11, 1'b1);
        out_ready = 1'b1;
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("clr2 ovr", {31'd0, overrun}, 32'd0);

        // Reset mid-word with a buffered word and overrun set.
        out_ready = 1'b0;
        send_word("pre-rst 33", 8'h33, 0, 1'b0, 8'h33, 1'b0);
        send_word("pre-rst drop", 8'h44, 0, 1'b0, 8'h33, 1'b1);
        for (int i = 0; i < 4; i++) begin
            shift_en = 1'b1;
            serial_in = 1'b1;
            tick();
        end
        idle_inputs();
        chk("mid cnt", {29'd0, bit_cnt}, 32'd4);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("rst valid", {31'd0, out_valid}, 32'd0);
        chk("rst data", {24'd0, parallel_out}, 32'd0);
        chk("rst ovr", {31'd0, overrun}, 32'd0);
        chk("rst cnt", {29'd0, bit_cnt}, 32'd0);
        out_ready = 1'b1;
        send_word("post-rst 5a", 8'h5A, 0, 1'b0, 8'h5A, 1'b0);
        tick();

        // Loopback from a PISO model, with junk bits first and sync on the first shift.
        for (int i = 0; i < 3; i++) begin
            shift_en = 1'b1;
            serial_in = 1'b1;
            tick();
        end
        piso = 8'hF0;
        for (int i = 0; i < 8; i++) begin
            shift_en  = 1'b1;
            sync      = (i == 0);
            serial_in = piso[7];
            piso      = {piso[6:0], 1'b0};
            tick();
        end
        idle_inputs();
        chk("loop valid", {31'd0, out_valid}, 32'd1);
        chk("loop data", {24'd0, parallel_out}, 32'hF0);
        chk("loop ovr", {31'd0, overrun}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
